// File: rtl/bnn_inference_scheduler_if.sv
// rtl/bnn_inference_scheduler_if.sv - byte input, weight-memory and result bundle for the BNN scheduler
// res_score is present only when BNN_SCORE_OUT_EN is defined.
interface bnn_inference_scheduler_if #(
  parameter int N_IN = 16,
  parameter int AW   = 4
);
  localparam int SW = $clog2(N_IN + 1);

  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_ready;
  logic            w_rd_en;
  logic [AW-1:0]   w_addr;
  logic [N_IN-1:0] w_data;
  logic            res_valid;
  logic [3:0]      res_class;
  logic            res_ready;
  logic            busy;
`ifdef BNN_SCORE_OUT_EN
  logic [SW-1:0]   res_score;

  modport master (
    input  in_valid, in_data, w_data, res_ready,
    output in_ready, w_rd_en, w_addr, res_valid, res_class, busy, res_score
  );
  modport slave (
    output in_valid, in_data, w_data, res_ready,
    input  in_ready, w_rd_en, w_addr, res_valid, res_class, busy, res_score
  );
`else
  modport master (
    input  in_valid, in_data, w_data, res_ready,
    output in_ready, w_rd_en, w_addr, res_valid, res_class, busy
  );
  modport slave (
    output in_valid, in_data, w_data, res_ready,
    input  in_ready, w_rd_en, w_addr, res_valid, res_class, busy
  );
`endif
endinterface

// File: rtl/bnn_inference_scheduler.sv
// rtl/bnn_inference_scheduler.sv - BNN output layer: byte-stream input, XNOR-popcount per neuron, argmax result
// Optional BNN_SCORE_OUT_EN exports the winning popcount on res_score.
module bnn_inference_scheduler #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bnn_inference_scheduler_if.master bus
);
  localparam int NB  = N_IN / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW  = $clog2(N_IN + 1);

  typedef enum logic [1:0] {S_LOAD, S_FETCH, S_ACC, S_RESULT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N_IN-1:0] r_x;
  logic [BCW-1:0]  r_bcnt;
  logic [AW-1:0]   r_idx;
  logic [SW-1:0]   r_best_score;
  logic [AW-1:0]   r_best_idx;
  logic [3:0]      r_res_class;

  logic            w_last_byte;
  logic            w_last_neuron;
  logic [N_IN-1:0] w_xnor;
  logic [SW-1:0]   w_score;
  logic            w_take;
  logic [SW-1:0]   w_upd_score;
  logic [AW-1:0]   w_upd_idx;

  assign w_last_byte   = (r_bcnt == BCW'(NB - 1));
  assign w_last_neuron = (r_idx == AW'(N_OUT - 1));

  always_comb begin
    w_xnor  = ~(r_x ^ bus.w_data);
    w_score = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_score = w_score + SW'(w_xnor[i]);
    end
  end

  // Neuron 0 always seeds the running best so an all-zero layer still reports class 0.
  assign w_take      = (r_idx == '0) || (w_score > r_best_score);
  assign w_upd_score = w_take ? w_score : r_best_score;
  assign w_upd_idx   = w_take ? r_idx   : r_best_idx;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.w_rd_en   = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && w_last_byte) w_next = S_FETCH;
      end
      S_FETCH: begin
        bus.w_rd_en = 1'b1;
        bus.busy    = 1'b1;
        w_next      = S_ACC;
      end
      S_ACC: begin
        bus.busy = 1'b1;
        w_next   = w_last_neuron ? S_RESULT : S_FETCH;
      end
      S_RESULT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

  assign bus.w_addr    = r_idx;
  assign bus.res_class = r_res_class;

`ifdef BNN_SCORE_OUT_EN
  logic [SW-1:0] r_res_score;
  assign bus.res_score = r_res_score;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x          <= '0;
      r_bcnt       <= '0;
      r_idx        <= '0;
      r_best_score <= '0;
      r_best_idx   <= '0;
      r_res_class  <= '0;
`ifdef BNN_SCORE_OUT_EN
      r_res_score  <= '0;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          if (bus.in_valid) begin
            r_x[int'(r_bcnt)*8 +: 8] <= bus.in_data;
            if (w_last_byte) begin
              r_bcnt       <= '0;
              r_idx        <= '0;
              r_best_score <= '0;
              r_best_idx   <= '0;
            end else begin
              r_bcnt <= r_bcnt + BCW'(1);
            end
          end
        end
        S_ACC: begin
          r_best_score <= w_upd_score;
          r_best_idx   <= w_upd_idx;
          if (w_last_neuron) begin
            r_res_class <= 4'(w_upd_idx);
`ifdef BNN_SCORE_OUT_EN
            r_res_score <= w_upd_score;
`endif
          end else begin
            r_idx <= r_idx + AW'(1);
          end
        end
        S_RESULT: begin
          if (bus.res_ready) r_bcnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bnn_inference_scheduler.sv
// tb/tb_bnn_inference_scheduler.sv - directed vector bench for bnn_inference_scheduler
module tb_bnn_inference_scheduler;
  localparam int N_IN  = 16;
  localparam int N_OUT = 10;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bnn_inference_scheduler_if #(.N_IN(N_IN), .AW(AW)) bus();

  bnn_inference_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0]   mem [0:15];
  logic [AW-1:0] rd_log [0:1023];
  int            rd_cnt = 0;

  always @(posedge clk) begin
    if (bus.w_rd_en) begin
      bus.w_data            <= mem[bus.w_addr];
      rd_log[rd_cnt % 1024] <= bus.w_addr;
      rd_cnt                <= rd_cnt + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] fill;
    int          a1;
    logic [15:0] w1;
    int          a2;
    logic [15:0] w2;
    int          gap;
    int          hold;
    bit          b2b;
    int          exp_class;
    int          exp_score;
  } vec_t;

  vec_t vecs [8];

  task automatic load_mem(input vec_t v);
    for (int i = 0; i < 16; i++) mem[i] = v.fill;
    if (v.a1 >= 0) mem[v.a1] = v.w1;
    if (v.a2 >= 0) mem[v.a2] = v.w2;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      errors++;
      checks++;
      $display("FAIL send_byte: in_ready never high");
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t        v;
    vec_t        nv;
    int          start;
    int          n;
    bit          ok;
    logic [15:0] xv;
    logic [15:0] nx;
    v = vecs[k];
    load_mem(v);
    start = rd_cnt;
    xv = v.x;
    send_byte(xv[7:0]);
    if (v.gap > 0) repeat (v.gap) @(negedge clk);
    send_byte(xv[15:8]);
    check($sformatf("v%0d first_rd", k), {31'd0, bus.w_rd_en}, 32'd1);
    check($sformatf("v%0d first_addr", k), {28'd0, bus.w_addr}, 32'd0);
    n = 0;
    while (!bus.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d latency", k), n, 32'd20);
    check($sformatf("v%0d class", k), {28'd0, bus.res_class}, v.exp_class);
`ifdef BNN_SCORE_OUT_EN
    check($sformatf("v%0d score", k), {27'd0, bus.res_score}, v.exp_score);
`endif
    check($sformatf("v%0d rd_count", k), rd_cnt - start, 32'd10);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rd_log[(start + i) % 1024] != AW'(i)) ok = 1'b0;
    end
    check($sformatf("v%0d addr_seq", k), {31'd0, ok}, 32'd1);
    repeat (v.hold) begin
      @(negedge clk);
      check($sformatf("v%0d hold", k),
            {24'd0, bus.res_valid, bus.in_ready, bus.w_rd_en, bus.busy, bus.res_class},
            {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'(v.exp_class)});
    end
    check($sformatf("v%0d in_ready_result", k), {31'd0, bus.in_ready}, 32'd0);
    bus.res_ready = 1'b1;
    if (v.b2b) begin
      nv = vecs[k + 1];
      nx = nv.x;
      bus.in_data  = nx[7:0];
      bus.in_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check($sformatf("v%0d load_after_hs", k),
          {30'd0, bus.in_ready, bus.res_valid}, 32'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          x         fill      a1  w1        a2  w2        gap hold b2b cls sc
    vecs[0] = '{16'h3CA5, 16'hC35A, 7,  16'h3CA5, -1, 16'h0000, 0,  5,   0,  7,  16};
    vecs[1] = '{16'h0000, 16'h0000, -1, 16'h0000, -1, 16'h0000, 0,  0,   1,  0,  16};
    vecs[2] = '{16'h0000, 16'hFFFF, 3,  16'h0000, 9,  16'h0000, 0,  1,   0,  3,  16};
    vecs[3] = '{16'hFFFF, 16'h0000, -1, 16'h0000, -1, 16'h0000, 0,  0,   0,  0,  0};
    vecs[4] = '{16'h00FF, 16'h0000, 5,  16'h00F0, 9,  16'h00FF, 0,  2,   0,  9,  16};
    vecs[5] = '{16'h1234, 16'h1234, 0,  16'hEDCB, -1, 16'h0000, 0,  0,   0,  1,  16};
    vecs[6] = '{16'h3412, 16'hCBED, 2,  16'h3412, -1, 16'h0000, 3,  0,   0,  2,  16};
    vecs[7] = '{16'hFFFF, 16'h0000, 6,  16'h000F, -1, 16'h0000, 0,  0,   0,  6,  4};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_state",
          {23'd0, bus.in_ready, bus.w_rd_en, bus.res_valid, bus.busy, bus.w_addr, bus.res_class},
          {23'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0});
`ifdef BNN_SCORE_OUT_EN
    check("reset_score", {27'd0, bus.res_score}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_vec(k);

    // Abort a run whose neurons all score 16, in ACC of neuron 4.
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (8) @(negedge clk);
    check("mid_fetch4", {27'd0, bus.w_rd_en, bus.w_addr}, {27'd0, 1'b1, 4'd4});
    @(negedge clk);
    check("mid_acc4", {30'd0, bus.busy, bus.w_rd_en}, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("after_rst",
          {28'd0, bus.in_ready, bus.res_valid, bus.busy, bus.w_rd_en}, 32'h8);
    run_vec(7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bnn_inference_scheduler.md
Name: bnn_inference_scheduler

Overview:
Sequences one binary-neural-network output layer for the BNN controller. It collects an input bit-vector as a byte stream from the UART receive side, then steps through N_OUT neurons. For each neuron it reads that neuron's weight word from weight memory and computes the XNOR-popcount score. It reports the index of the highest-scoring neuron (argmax class) to the UART transmit side using a valid/ready handshake.

Parameters:
N_IN, 16, input vector width in bits; multiple of 8; range 8..64
N_OUT, 10, number of output neurons; range 2..16
AW, 4, weight memory address width; must satisfy 2^AW >= N_OUT

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  input byte available
in_data  input  8  input byte; the first byte fills bits [7:0] of the vector
in_ready  output  1  scheduler accepts a byte this cycle
w_rd_en  output  1  weight memory read strobe
w_addr  output  AW  weight address, equal to the neuron index
w_data  input  N_IN  weight word; valid exactly 1 cycle after w_rd_en
res_valid  output  1  result available
res_class  output  4  winning neuron index, zero-extended
res_ready  input  1  consumer accepts the result
busy  output  1  high in FETCH and ACC

Behaviour:
- States: LOAD, FETCH, ACC, RESULT. Reset state is LOAD.
- Reset values: in_ready=1 (LOAD), w_rd_en=0, w_addr=0, res_valid=0, res_class=0, busy=0. Byte count, neuron index, best score and best index all clear to 0.
- Reset has priority over all other events, in any state. Asserting rst mid-operation abandons the partial vector and any pending result. The first cycle after reset is LOAD with nothing captured.
- LOAD:
  - in_ready=1.
  - A byte is accepted on every edge where in_valid=1. Byte k is stored into x[8k+7:8k].
  - When the (N_IN/8)-th byte is accepted: go to FETCH, set neuron index to 0, set best score to 0, set best index to 0.
- FETCH:
  - w_rd_en=1, w_addr=neuron index.
  - Unconditionally go to ACC on the next edge.
- ACC:
  - score = popcount(~(x ^ w_data)), width clog2(N_IN+1).
  - Update best score and best index only if score > best score (strictly greater). On a tie the lower index is kept.
  - Exception: neuron 0 always loads its score, so an all-zero score still yields class 0.
  - If neuron index == N_OUT-1: go to RESULT, with res_class taken from the updated best index. Otherwise increment the index and go to FETCH.
- RESULT:
  - res_valid=1. res_class is held stable until handshake.
  - On res_valid && res_ready: go to LOAD, res_valid=0, byte count=0.
  - in_ready=0 throughout RESULT; upstream back-pressure is therefore automatic.
- Latency: if the last byte is accepted at edge E, w_rd_en is high in the cycle after E, and res_valid rises at edge E + 2*N_OUT.
- w_rd_en is never asserted outside FETCH. w_addr never exceeds N_OUT-1.
- busy = (state==FETCH || state==ACC).
- in_valid is ignored outside LOAD. res_ready is ignored outside RESULT.

Optional Feature:
- BNN_SCORE_OUT_EN defined:
  - Adds output port res_score, width clog2(N_IN+1), carrying the winning popcount.
  - Valid alongside res_valid and held with res_class. Reset value 0.
- BNN_SCORE_OUT_EN undefined:
  - The port does not exist. The best-score register is retained internally for comparison only.
  - All other behaviour is identical.

Test Plan:
- Basic argmax: bytes 0xA5, 0x3C (x=16'h3CA5). Memory holds ~x at every address except addr 7 = 16'h3CA5. Required: res_valid rises exactly 20 edges after the second byte is accepted; res_class=7; res_score=16 when BNN_SCORE_OUT_EN is defined.
- Tie-break: x=16'h0000, all weights 16'h0000 (every score 16). Required: res_class=0. Separately, weights 16'hFFFF except addr 3 = 16'h0000 and addr 9 = 16'h0000. Required: res_class=3.
- Input gaps: in_valid pulses 1 cycle on, 3 off, for bytes 0x12, 0x34. Required: exactly 2 bytes captured (x=16'h3412); first w_rd_en in the cycle after the second accept; w_addr steps 0..9, each address held for one read.
- Result back-pressure: hold res_ready=0 for 5 cycles after res_valid. Required: res_valid and res_class stable; in_ready=0; w_rd_en=0. When res_ready=1: back to LOAD with in_ready=1 on the next cycle.
- Reset mid-run: assert rst for 1 cycle while in ACC at neuron 4. Required: the next cycle shows LOAD, res_valid=0, busy=0, in_ready=1. A fresh 2-byte vector then produces the correct class, with no leftover best score from the aborted run.
- Back-to-back: present the next vector's first byte in the same cycle as the res_ready handshake. Required: that byte is not accepted (in_ready=0 in RESULT); it is accepted on the following cycle. Both results are correct.
